// File: rtl/punc_ctrl_pkg.sv
// Shared encodings for the PUnC sequencing controller: opcodes, FSM states and
// the datapath select values driven onto addr_sel, pc_sel, rf_wsel and alu_op.
package punc_ctrl_pkg;

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_STR  = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_STI  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RES  = 4'hD;
  localparam logic [3:0] OP_LEA  = 4'hE;
  localparam logic [3:0] OP_TRAP = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_EXEC2,
    ST_HALT
  } state_e;

  localparam logic [1:0] ADDR_PC        = 2'd0;
  localparam logic [1:0] ADDR_PC_OFF9   = 2'd1;
  localparam logic [1:0] ADDR_BASE_OFF6 = 2'd2;
  localparam logic [1:0] ADDR_IND       = 2'd3;

  localparam logic [1:0] PC_SEL_OFF9  = 2'd0;
  localparam logic [1:0] PC_SEL_OFF11 = 2'd1;
  localparam logic [1:0] PC_SEL_BASE  = 2'd2;

  localparam logic [1:0] WSEL_PC      = 2'd0;
  localparam logic [1:0] WSEL_MEM     = 2'd1;
  localparam logic [1:0] WSEL_ALU     = 2'd2;
  localparam logic [1:0] WSEL_PC_OFF9 = 2'd3;

  localparam logic [1:0] ALU_ADD    = 2'd0;
  localparam logic [1:0] ALU_AND    = 2'd1;
  localparam logic [1:0] ALU_PASS_A = 2'd2;
  localparam logic [1:0] ALU_NOT    = 2'd3;

  localparam logic [2:0] REG_R7 = 3'd7;

endpackage

// File: rtl/punc_hs_timer.sv
// Memory handshake wait counter: cleared on entry to a waiting state, counts
// stalled request cycles and flags the last cycle allowed before a timeout.
module punc_hs_timer #(
  parameter int unsigned TIMEOUT_CYC = 0,
  parameter int unsigned TMR_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  // at_limit marks the stalled cycle that would make the count reach TIMEOUT_CYC
  localparam logic [TMR_W-1:0] LIMIT_M1 = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

  assign at_limit = (TIMEOUT_CYC != 0) && (cnt == LIMIT_M1);

endmodule

// File: rtl/punc_seq_ctrl.sv
// Multi-cycle LC3 control FSM for the PUnC datapath with a variable-latency
// memory handshake, optional access timeout and single-step instruction gating.
module punc_seq_ctrl
  import punc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 0,
  parameter int unsigned TMR_W       = 8,
  parameter bit          STEP_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  input  logic        n,
  input  logic        z,
  input  logic        p,
  input  logic        mem_ack,
  input  logic        step_mode,
  input  logic        step,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  addr_sel,
  output logic        ir_ld,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic        ind_ld,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [2:0]  rf_raddr0,
  output logic [2:0]  rf_raddr1,
  output logic [1:0]  rf_wsel,
  output logic        b_sel,
  output logic [1:0]  alu_op,
  output logic        nzp_ld,
  output logic        nzp_sel,
  output logic        halted,
  output logic        mem_err
);

  state_e     state, state_next;
  logic       token;
  logic       err_q;
  logic       tmo;
  logic       at_limit;
  logic       step_on;
  logic [3:0] opcode;
  logic [2:0] dr, sr1, sr2;
  logic       unused_ir;

  assign opcode    = ir[15:12];
  assign dr        = ir[11:9];
  assign sr1       = ir[8:6];
  assign sr2       = ir[2:0];
  assign unused_ir = ^ir[4:3];
  assign step_on   = STEP_EN && step_mode;

  punc_hs_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMR_W       (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_next != state),
    .inc      (mem_req & ~mem_ack),
    .at_limit (at_limit)
  );

  // State, step token and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      token <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (ir_ld) begin
        token <= 1'b0;
      end else if (step) begin
        token <= 1'b1;
      end
      if (tmo) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    tmo        = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = ADDR_PC;
    ir_ld      = 1'b0;
    pc_inc     = 1'b0;
    pc_ld      = 1'b0;
    ind_ld     = 1'b0;
    pc_sel     = PC_SEL_OFF9;
    rf_we      = 1'b0;
    rf_waddr   = 3'd0;
    rf_raddr0  = 3'd0;
    rf_raddr1  = 3'd0;
    rf_wsel    = WSEL_PC;
    b_sel      = 1'b0;
    alu_op     = ALU_ADD;
    nzp_ld     = 1'b0;
    nzp_sel    = 1'b0;
    halted     = 1'b0;
    mem_err    = 1'b0;

    if (!rst) begin
      unique case (state)
        ST_FETCH: begin
          if (!step_on || token) begin
            mem_req  = 1'b1;
            addr_sel = ADDR_PC;
            if (mem_ack) begin
              ir_ld      = 1'b1;
              pc_inc     = 1'b1;
              state_next = ST_DECODE;
            end
          end
        end

        ST_DECODE: state_next = (opcode == OP_TRAP) ? ST_HALT : ST_EXEC;

        ST_EXEC: begin
          state_next = ST_FETCH;
          case (opcode)
            OP_ADD, OP_AND, OP_NOT: begin
              rf_we     = 1'b1;
              rf_waddr  = dr;
              rf_raddr0 = sr1;
              rf_raddr1 = sr2;
              rf_wsel   = WSEL_ALU;
              nzp_ld    = 1'b1;
              b_sel     = (opcode == OP_NOT) ? 1'b0 : ir[5];
              alu_op    = (opcode == OP_ADD) ? ALU_ADD :
                          (opcode == OP_AND) ? ALU_AND : ALU_NOT;
            end
            OP_BR: begin
              pc_ld  = |(ir[11:9] & {n, z, p});
              pc_sel = PC_SEL_OFF9;
            end
            OP_JMP: begin
              pc_ld     = 1'b1;
              pc_sel    = PC_SEL_BASE;
              rf_raddr0 = sr1;
            end
            // Base register is read this cycle, before the R7 write lands
            OP_JSR: begin
              rf_we     = 1'b1;
              rf_waddr  = REG_R7;
              rf_wsel   = WSEL_PC;
              pc_ld     = 1'b1;
              pc_sel    = ir[11] ? PC_SEL_OFF11 : PC_SEL_BASE;
              rf_raddr0 = sr1;
            end
            OP_LEA: begin
              rf_we    = 1'b1;
              rf_waddr = dr;
              rf_wsel  = WSEL_PC_OFF9;
            end
            OP_LD, OP_LDR: begin
              mem_req   = 1'b1;
              addr_sel  = (opcode == OP_LD) ? ADDR_PC_OFF9 : ADDR_BASE_OFF6;
              rf_raddr0 = sr1;
              rf_waddr  = dr;
              rf_wsel   = WSEL_MEM;
              nzp_sel   = 1'b1;
              rf_we     = mem_ack;
              nzp_ld    = mem_ack;
              if (!mem_ack) state_next = ST_EXEC;
            end
            OP_ST, OP_STR: begin
              mem_req   = 1'b1;
              mem_we    = 1'b1;
              addr_sel  = (opcode == OP_ST) ? ADDR_PC_OFF9 : ADDR_BASE_OFF6;
              rf_raddr0 = sr1;
              rf_raddr1 = dr;
              if (!mem_ack) state_next = ST_EXEC;
            end
            OP_LDI, OP_STI: begin
              mem_req    = 1'b1;
              addr_sel   = ADDR_PC_OFF9;
              ind_ld     = mem_ack;
              state_next = mem_ack ? ST_EXEC2 : ST_EXEC;
            end
            default: ;
          endcase
        end

        ST_EXEC2: begin
          mem_req    = 1'b1;
          addr_sel   = ADDR_IND;
          state_next = mem_ack ? ST_FETCH : ST_EXEC2;
          if (opcode == OP_STI) begin
            mem_we    = 1'b1;
            rf_raddr1 = dr;
          end else begin
            rf_waddr = dr;
            rf_wsel  = WSEL_MEM;
            nzp_sel  = 1'b1;
            rf_we    = mem_ack;
            nzp_ld   = mem_ack;
          end
        end

        ST_HALT: halted = 1'b1;

        default: state_next = ST_FETCH;
      endcase

      // Stalled too long: abandon the access; strobes are already idle without ack
      if (mem_req && !mem_ack && at_limit) begin
        tmo        = 1'b1;
        state_next = ST_HALT;
      end
      mem_err = err_q;
    end
  end

endmodule

// File: tb/tb_punc_seq_ctrl.sv
// Self-checking bench for punc_seq_ctrl: directed scenarios plus randomized
// instructions and memory latencies, checked against an instruction-level model.
module tb_punc_seq_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic [1:0] addr_sel;
    logic       ir_ld;
    logic       pc_inc;
    logic       pc_ld;
    logic       ind_ld;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [2:0] rf_raddr0;
    logic [2:0] rf_raddr1;
    logic [1:0] rf_wsel;
    logic       b_sel;
    logic [1:0] alu_op;
    logic       nzp_ld;
    logic       nzp_sel;
    logic       halted;
    logic       mem_err;
  } outs_t;

  localparam int TMO = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir = 16'h0;
  logic        n = 1'b0, z = 1'b0, p = 1'b0;
  logic        mem_ack = 1'b0, step_mode = 1'b0, step = 1'b0;

  logic       mem_req, mem_we, ir_ld, pc_inc, pc_ld, ind_ld, rf_we, b_sel;
  logic       nzp_ld, nzp_sel, halted, mem_err;
  logic [1:0] addr_sel, pc_sel, rf_wsel, alu_op;
  logic [2:0] rf_waddr, rf_raddr0, rf_raddr1;

  int tests = 0;
  int fails = 0;

  punc_seq_ctrl #(.TIMEOUT_CYC(TMO), .TMR_W(8), .STEP_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
    .mem_ack(mem_ack), .step_mode(step_mode), .step(step),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld), .ind_ld(ind_ld),
    .pc_sel(pc_sel), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_wsel(rf_wsel),
    .b_sel(b_sel), .alu_op(alu_op), .nzp_ld(nzp_ld), .nzp_sel(nzp_sel),
    .halted(halted), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic outs_t observe();
    outs_t o;
    o.mem_req = mem_req;     o.mem_we = mem_we;       o.addr_sel = addr_sel;
    o.ir_ld = ir_ld;         o.pc_inc = pc_inc;       o.pc_ld = pc_ld;
    o.ind_ld = ind_ld;       o.pc_sel = pc_sel;       o.rf_we = rf_we;
    o.rf_waddr = rf_waddr;   o.rf_raddr0 = rf_raddr0; o.rf_raddr1 = rf_raddr1;
    o.rf_wsel = rf_wsel;     o.b_sel = b_sel;         o.alu_op = alu_op;
    o.nzp_ld = nzp_ld;       o.nzp_sel = nzp_sel;     o.halted = halted;
    o.mem_err = mem_err;
    return o;
  endfunction

  // Expected controls while executing instruction ins; acc = index of its memory access
  function automatic outs_t model_exec(input logic [15:0] ins, input logic [2:0] cc,
                                       input int acc, input logic ack);
    outs_t e;
    logic [3:0] op;
    logic [2:0] dr, sr1, sr2;
    bit ind, load, store;
    e = '0;
    op = ins[15:12]; dr = ins[11:9]; sr1 = ins[8:6]; sr2 = ins[2:0];
    ind   = (op == 4'hA) || (op == 4'hB);
    load  = (op == 4'h2) || (op == 4'h6) || (op == 4'hA);
    store = (op == 4'h3) || (op == 4'h7) || (op == 4'hB);
    if (op == 4'h1 || op == 4'h5 || op == 4'h9) begin
      e.rf_we = 1'b1; e.rf_waddr = dr; e.rf_raddr0 = sr1; e.rf_raddr1 = sr2;
      e.rf_wsel = 2'd2; e.nzp_ld = 1'b1;
      e.alu_op = (op == 4'h1) ? 2'd0 : (op == 4'h5) ? 2'd1 : 2'd3;
      e.b_sel  = (op == 4'h9) ? 1'b0 : ins[5];
    end else if (op == 4'h0) begin
      e.pc_ld = |(ins[11:9] & cc);
    end else if (op == 4'hC) begin
      e.pc_ld = 1'b1; e.pc_sel = 2'd2; e.rf_raddr0 = sr1;
    end else if (op == 4'h4) begin
      e.rf_we = 1'b1; e.rf_waddr = 3'd7; e.pc_ld = 1'b1; e.rf_raddr0 = sr1;
      e.pc_sel = ins[11] ? 2'd1 : 2'd2;
    end else if (op == 4'hE) begin
      e.rf_we = 1'b1; e.rf_waddr = dr; e.rf_wsel = 2'd3;
    end else if (load || store) begin
      e.mem_req = 1'b1;
      if (ind && acc == 0) begin
        e.addr_sel = 2'd1; e.ind_ld = ack;
      end else begin
        e.addr_sel = ind ? 2'd3 : (op[2] ? 2'd2 : 2'd1);
        if (!ind) e.rf_raddr0 = sr1;
        if (load) begin
          e.rf_waddr = dr; e.rf_wsel = 2'd1; e.nzp_sel = 1'b1;
          e.rf_we = ack; e.nzp_ld = ack;
        end else begin
          e.mem_we = 1'b1; e.rf_raddr1 = dr;
        end
      end
    end
    return e;
  endfunction

  // Fetch, decode and execute one instruction; starts and ends at posedge+1 in FETCH
  task automatic run_instr(input string name, input logic [15:0] ins, input logic [2:0] cc,
                           input int lat_f, input int lat_m,
                           output int n_req, output int n_ind, output int n_rfwe,
                           output int n_pcld);
    outs_t o, e;
    int nacc;
    logic [3:0] op;
    n_req = 0; n_ind = 0; n_rfwe = 0; n_pcld = 0;
    op = ins[15:12];
    ir = 16'($urandom);
    {n, z, p} = 3'($urandom);
    for (int c = 0; c <= lat_f; c++) begin
      mem_ack = (c == lat_f);
      @(negedge clk);
      o = observe();
      e = '0; e.mem_req = 1'b1; e.ir_ld = mem_ack; e.pc_inc = mem_ack;
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL %s fetch cyc=%0d got=%h exp=%h", name, c, o, e);
      end
      @(posedge clk); #1;
    end
    ir = ins;
    mem_ack = 1'($urandom);
    @(negedge clk);
    o = observe();
    tests++;
    if (o !== outs_t'('0)) begin
      fails++;
      $display("FAIL %s decode got=%h exp=0", name, o);
    end
    @(posedge clk); #1;
    {n, z, p} = cc;
    if (op == 4'hF) begin
      for (int c = 0; c < 3; c++) begin
        mem_ack = 1'($urandom);
        step = 1'($urandom);
        @(negedge clk);
        o = observe();
        e = '0; e.halted = 1'b1;
        tests++;
        if (o !== e) begin
          fails++;
          $display("FAIL %s halt cyc=%0d got=%h exp=%h", name, c, o, e);
        end
        @(posedge clk); #1;
      end
      step = 1'b0;
      mem_ack = 1'b0;
      return;
    end
    nacc = (op inside {4'h2, 4'h3, 4'h6, 4'h7}) ? 1 : (op inside {4'hA, 4'hB}) ? 2 : 0;
    if (nacc == 0) begin
      mem_ack = 1'($urandom);
      @(negedge clk);
      o = observe();
      e = model_exec(ins, cc, 0, mem_ack);
      n_rfwe += int'(o.rf_we); n_pcld += int'(o.pc_ld);
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL %s exec ir=%h got=%h exp=%h", name, ins, o, e);
      end
      @(posedge clk); #1;
    end else begin
      for (int a = 0; a < nacc; a++) begin
        for (int c = 0; c <= lat_m; c++) begin
          mem_ack = (c == lat_m);
          @(negedge clk);
          o = observe();
          e = model_exec(ins, cc, a, mem_ack);
          n_req += int'(o.mem_req); n_ind += int'(o.ind_ld);
          n_rfwe += int'(o.rf_we); n_pcld += int'(o.pc_ld);
          tests++;
          if (o !== e) begin
            fails++;
            $display("FAIL %s access=%0d cyc=%0d ir=%h got=%h exp=%h", name, a, c, ins, o, e);
          end
          @(posedge clk); #1;
        end
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    outs_t o;
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ir = 16'($urandom); {n, z, p} = 3'($urandom);
      mem_ack = 1'($urandom); step_mode = 1'($urandom); step = 1'($urandom);
      @(negedge clk);
      o = observe();
      tests++;
      if (o !== outs_t'('0)) begin
        fails++;
        $display("FAIL reset_outputs cyc=%0d got=%h exp=0", c, o);
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0; step_mode = 1'b0; step = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_add();
    int q, i, w, pl;
    // ADD R1,R2,#-3 with zero-latency fetch
    run_instr("add_imm", 16'h12BD, 3'b001, 0, 0, q, i, w, pl);
    tests++;
    if (w != 1) begin
      fails++;
      $display("FAIL add_rf_we count got=%0d exp=1", w);
    end
    #1;
    tests++;
    if (mem_req !== 1'b1 || ir_ld !== 1'b0 || addr_sel !== 2'd0) begin
      fails++;
      $display("FAIL add_back_to_fetch got req=%b ir_ld=%b addr_sel=%0d exp req=1 ir_ld=0 addr_sel=0",
               mem_req, ir_ld, addr_sel);
    end
  endtask

  task automatic test_br();
    int q, i, w, pl;
    run_instr("brz_not_taken", {4'h0, 3'b010, 9'h1A5}, 3'b101, 1, 0, q, i, w, pl);
    tests++;
    if (pl != 0) begin fails++; $display("FAIL brz_z0 pc_ld got=%0d exp=0", pl); end
    run_instr("brz_taken", {4'h0, 3'b010, 9'h1A5}, 3'b010, 0, 0, q, i, w, pl);
    tests++;
    if (pl != 1) begin fails++; $display("FAIL brz_z1 pc_ld got=%0d exp=1", pl); end
    run_instr("br_none", {4'h0, 3'b000, 9'h033}, 3'b111, 2, 0, q, i, w, pl);
    tests++;
    if (pl != 0) begin fails++; $display("FAIL br_nzp000 pc_ld got=%0d exp=0", pl); end
  endtask

  task automatic test_ldi();
    int q, i, w, pl;
    run_instr("ldi_r3", {4'hA, 3'd3, 9'h055}, 3'b000, 4, 4, q, i, w, pl);
    tests++;
    if (q != 10 || i != 1 || w != 1) begin
      fails++;
      $display("FAIL ldi_counts got req=%0d ind_ld=%0d rf_we=%0d exp req=10 ind_ld=1 rf_we=1", q, i, w);
    end
  endtask

  task automatic test_jsrr();
    int q, i, w, pl;
    run_instr("jsrr_r7", 16'h41C0, 3'b000, 0, 0, q, i, w, pl);
    tests++;
    if (pl != 1 || w != 1) begin
      fails++;
      $display("FAIL jsrr_strobes got pc_ld=%0d rf_we=%0d exp 1 1", pl, w);
    end
  endtask

  task automatic test_random();
    int q, i, w, pl;
    logic [3:0] op;
    for (int k = 0; k < 150; k++) begin
      op = 4'($urandom_range(0, 14));
      run_instr("rand", {op, 12'($urandom)}, 3'($urandom),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), q, i, w, pl);
    end
  endtask

  task automatic test_step();
    int q, i, w, pl;
    outs_t o, e;
    step_mode = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < ((r == 0) ? 5 : 20); c++) begin
        mem_ack = 1'($urandom);
        @(negedge clk);
        o = observe();
        tests++;
        if (o !== outs_t'('0)) begin
          fails++;
          $display("FAIL step_idle round=%0d cyc=%0d got=%h exp=0", r, c, o);
        end
        @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      step = 1'b1;
      @(negedge clk);
      o = observe();
      tests++;
      if (o !== outs_t'('0)) begin
        fails++;
        $display("FAIL step_pulse round=%0d got=%h exp=0", r, o);
      end
      @(posedge clk); #1;
      // Last round: a second pulse while the token is held must be lost
      if (r == 2) begin
        @(negedge clk);
        o = observe();
        e = '0; e.mem_req = 1'b1;
        tests++;
        if (o !== e) begin
          fails++;
          $display("FAIL step_double got=%h exp=%h", o, e);
        end
        @(posedge clk); #1;
      end
      step = 1'b0;
      run_instr("step_instr", {4'h5, 12'($urandom)}, 3'b000, 0, 0, q, i, w, pl);
    end
    for (int c = 0; c < 20; c++) begin
      mem_ack = 1'($urandom);
      @(negedge clk);
      o = observe();
      tests++;
      if (o !== outs_t'('0)) begin
        fails++;
        $display("FAIL step_after_double cyc=%0d got=%h exp=0", c, o);
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    step_mode = 1'b0;
  endtask

  task automatic test_timeout();
    outs_t o, e;
    mem_ack = 1'b0;
    ir = 16'($urandom);
    for (int c = 0; c <= TMO + 3; c++) begin
      if (c > TMO) mem_ack = 1'($urandom);
      @(negedge clk);
      o = observe();
      e = '0;
      if (c < TMO) e.mem_req = 1'b1;
      else begin e.halted = 1'b1; e.mem_err = 1'b1; end
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL timeout cyc=%0d got=%h exp=%h", c, o, e);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    o = observe();
    tests++;
    if (o !== outs_t'('0)) begin
      fails++;
      $display("FAIL timeout_in_reset got=%h exp=0", o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    o = observe();
    e = '0; e.mem_req = 1'b1;
    tests++;
    if (o !== e) begin
      fails++;
      $display("FAIL timeout_cleared got=%h exp=%h", o, e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_halt();
    int q, i, w, pl;
    outs_t o, e;
    // Abandon a stalled fetch with reset; the new fetch must see a cleared timer
    mem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    o = observe();
    tests++;
    if (o !== outs_t'('0)) begin
      fails++;
      $display("FAIL reset_mid_access got=%h exp=0", o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr("after_abort", {4'h9, 12'($urandom)}, 3'b000, TMO - 1, 0, q, i, w, pl);
    run_instr("trap_halt", 16'hF025, 3'b000, 1, 0, q, i, w, pl);
    rst = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    o = observe();
    tests++;
    if (o !== outs_t'('0)) begin
      fails++;
      $display("FAIL halt_reset got=%h exp=0", o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    o = observe();
    e = '0; e.mem_req = 1'b1;
    tests++;
    if (o !== e) begin
      fails++;
      $display("FAIL halt_exit_fetch got=%h exp=%h", o, e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_br();
    test_ldi();
    test_jsrr();
    test_random();
    test_step();
    test_timeout();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
